// File: rtl/grid_pkg.sv
// Shared constants and enums for the grid text-ingest path.
package grid_pkg;

    localparam logic [7:0] CH_ROLL  = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ERR  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_ROLL  = 3'd0,
        C_EMPTY = 3'd1,
        C_NL    = 3'd2,
        C_IGN   = 3'd3,
        C_BAD   = 3'd4
    } cls_t;

endpackage

// File: rtl/grid_char_decode.sv
// Classifies one ASCII byte of puzzle text.
module grid_char_decode
    import grid_pkg::*;
(
    input  logic [7:0] i_byte,
    output cls_t       o_cls
);

    always_comb begin
        o_cls = C_BAD;
        unique case (1'b1)
            (i_byte == CH_ROLL):  o_cls = C_ROLL;
            (i_byte == CH_EMPTY): o_cls = C_EMPTY;
            (i_byte == CH_NL):    o_cls = C_NL;
            (i_byte == CH_CR):    o_cls = C_IGN;
            default:              o_cls = C_BAD;
        endcase
    end

endmodule

// File: rtl/grid_stream_loader.sv
// Streams puzzle text into an occupancy frame and holds it until acked.
module grid_stream_loader
    import grid_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_data,
    input  logic                               in_last,
    output logic [WIDTH*DEPTH-1:0]             grid,
    output logic [$clog2(DEPTH+1)-1:0]         rows,
    output logic [$clog2(WIDTH+1)-1:0]         cols,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0]   roll_count,
    output logic                               grid_valid,
    output logic                               grid_err,
    input  logic                               grid_ack
);

    localparam int CW = $clog2(WIDTH+1);
    localparam int RW = $clog2(DEPTH+1);
    localparam int NW = $clog2(WIDTH*DEPTH+1);
    localparam int IW = $clog2(WIDTH*DEPTH);

    state_t                 r_state;
    logic [WIDTH*DEPTH-1:0] r_grid;
    logic [RW-1:0]          r_rows;
    logic [CW-1:0]          r_cols;
    logic [CW-1:0]          r_col;
    logic [NW-1:0]          r_rolls;
    logic                   r_first;
    logic                   r_err;

    cls_t          w_cls;
    logic          w_acc;
    logic          w_cell;
    logic          w_cell_err;
    logic          w_close;
    logic          w_wid_err;
    logic          w_err;
    logic [CW-1:0] w_col_adv;
    logic [RW-1:0] w_rows_nxt;
    logic [IW-1:0] w_idx;

    grid_char_decode u_dec (
        .i_byte (in_data),
        .o_cls  (w_cls)
    );

    assign w_acc      = in_valid && (r_state != DONE);
    assign w_cell     = (w_cls == C_ROLL) || (w_cls == C_EMPTY);
    assign w_cell_err = w_cell &&
                        ((r_col == CW'(WIDTH)) || (r_rows == RW'(DEPTH)));
    assign w_col_adv  = r_col + CW'(w_cell);
    // in_last closes an unterminated row exactly like a trailing newline
    assign w_close    = !w_cell_err && (w_cls != C_BAD) &&
                        (w_col_adv != '0) &&
                        ((w_cls == C_NL) || in_last);
    assign w_wid_err  = w_close && r_first && (w_col_adv != r_cols);
    assign w_err      = w_cell_err || (w_cls == C_BAD) || w_wid_err;
    assign w_rows_nxt = r_rows + RW'(w_close);
    assign w_idx      = IW'(int'(r_rows) * WIDTH + int'(r_col));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_grid  <= '0;
            r_rows  <= '0;
            r_cols  <= '0;
            r_col   <= '0;
            r_rolls <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    if (w_acc) begin
                        if (w_cell && !w_cell_err) begin
                            if (w_cls == C_ROLL) begin
                                r_grid[w_idx] <= 1'b1;
                                r_rolls       <= r_rolls + NW'(1);
                            end
                            r_col <= w_col_adv;
                        end
                        if (w_close) begin
                            r_rows <= w_rows_nxt;
                            r_col  <= '0;
                            if (!r_first) begin
                                r_cols  <= w_col_adv;
                                r_first <= 1'b1;
                            end
                        end
                        if (in_last) begin
                            r_state <= DONE;
                            r_err   <= w_err || (w_rows_nxt == '0);
                        end else if (w_err) begin
                            r_state <= ERR;
                        end
                    end
                end
                ERR: begin
                    if (w_acc && in_last) begin
                        r_state <= DONE;
                        r_err   <= 1'b1;
                    end
                end
                DONE: begin
                    if (grid_ack) begin
                        r_state <= LOAD;
                        r_grid  <= '0;
                        r_rows  <= '0;
                        r_cols  <= '0;
                        r_col   <= '0;
                        r_rolls <= '0;
                        r_first <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready   = (r_state != DONE);
    assign grid       = r_grid;
    assign rows       = r_rows;
    assign cols       = r_cols;
    assign roll_count = r_rolls;
    assign grid_valid = (r_state == DONE);
    assign grid_err   = r_err;

endmodule

// File: tb/tb_grid_stream_loader.sv
// Scoreboard bench: text frames vs a line-based reference parser.
module tb_grid_stream_loader;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int N     = WIDTH * DEPTH;

    localparam byte unsigned AT  = 8'h40;
    localparam byte unsigned DOT = 8'h2E;
    localparam byte unsigned NL  = 8'h0A;
    localparam byte unsigned CR  = 8'h0D;

    logic                             clk;
    logic                             rst_n;
    logic                             in_valid;
    logic                             in_ready;
    logic [7:0]                       in_data;
    logic                             in_last;
    logic [N-1:0]                     grid;
    logic [$clog2(DEPTH+1)-1:0]       rows;
    logic [$clog2(WIDTH+1)-1:0]       cols;
    logic [$clog2(N+1)-1:0]           roll_count;
    logic                             grid_valid;
    logic                             grid_err;
    logic                             grid_ack;

    grid_stream_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .grid       (grid),
        .rows       (rows),
        .cols       (cols),
        .roll_count (roll_count),
        .grid_valid (grid_valid),
        .grid_err   (grid_err),
        .grid_ack   (grid_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           err;
        int           rows;
        int           cols;
        int           rolls;
        logic [N-1:0] grid;
    } exp_t;

    exp_t         sb[$];
    byte unsigned f[$];
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a file is a list of lines; cells collect per line
    function automatic exp_t model(input byte unsigned s[$]);
        exp_t         e;
        byte unsigned cur[$];
        bit           err;
        e   = '{err: 1'b0, rows: 0, cols: 0, rolls: 0, grid: '0};
        err = 1'b0;
        foreach (s[i]) begin
            if (err) break;
            if (s[i] == AT || s[i] == DOT) begin
                if (cur.size() >= WIDTH || e.rows >= DEPTH) err = 1'b1;
                else begin
                    cur.push_back(s[i]);
                    if (s[i] == AT) e.rolls++;
                end
            end else if (s[i] != NL && s[i] != CR) begin
                err = 1'b1;
            end
            if (!err && cur.size() > 0 && (s[i] == NL || i == s.size() - 1)) begin
                if (e.rows > 0 && cur.size() != e.cols) err = 1'b1;
                else begin
                    if (e.rows == 0) e.cols = cur.size();
                    foreach (cur[k]) e.grid[e.rows*WIDTH + k] = (cur[k] == AT);
                    e.rows++;
                    cur.delete();
                end
            end
        end
        if (!err && e.rows == 0) err = 1'b1;
        e.err = err;
        return e;
    endfunction

    task automatic send_byte(input byte unsigned b, input bit l);
        int n;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input byte unsigned s[$]);
        sb.push_back(model(s));
        foreach (s[i]) send_byte(s[i], i == s.size() - 1);
        chk("valid_latency", grid_valid, 1);
    endtask

    task automatic str2q(input string t, output byte unsigned q[$]);
        q = {};
        for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
    endtask

    task automatic gen(input int w, input int h, input int mode,
                       output byte unsigned q[$]);
        int wr;
        q = {};
        if (mode == 4) q.push_back(NL);
        for (int r = 0; r < h; r++) begin
            wr = w;
            if (mode == 1 && r == h - 1 && h > 1) wr = (w < WIDTH) ? w + 1 : w - 1;
            for (int c = 0; c < wr; c++)
                q.push_back($urandom_range(0, 1) ? AT : DOT);
            if (mode == 2) q.push_back(CR);
            if (!(mode == 3 && r == h - 1)) q.push_back(NL);
        end
        if (mode == 4) begin
            q.push_back(NL);
            q.push_back(NL);
        end
        if (mode == 0)
            q.insert($urandom_range(0, q.size() - 1), 8'($urandom_range(0, 255)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || grid_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: compares each presented frame, then acknowledges it
    initial begin
        exp_t e;
        int   d;
        grid_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!grid_valid) begin
                grid_ack = ($urandom_range(0, 7) == 0);
            end else begin
                grid_ack = 1'b0;
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL spurious_frame: got valid expected none");
                end else begin
                    e = sb.pop_front();
                    chk("grid_err", grid_err, e.err);
                    chk("roll_count", roll_count, e.rolls);
                    if (!e.err) begin
                        chk("rows", rows, e.rows);
                        chk("cols", cols, e.cols);
                        checks++;
                        if (grid !== e.grid) begin
                            errors++;
                            $display("FAIL grid: got %h expected %h", grid, e.grid);
                        end
                    end
                end
                d = $urandom_range(1, 3);
                repeat (d) begin
                    @(negedge clk);
                    chk("ready_in_done", in_ready, 0);
                    chk("valid_held", grid_valid, 1);
                end
                grid_ack = 1'b1;
                @(negedge clk);
                grid_ack = 1'b0;
                chk("ack_valid_clear", grid_valid, 0);
                chk("ack_grid_clear", (grid != '0), 0);
                chk("ack_rows_clear", rows, 0);
                chk("ack_rolls_clear", roll_count, 0);
                chk("ack_err_clear", grid_err, 0);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", grid_valid, 0);
        chk("rst_err", grid_err, 0);
        chk("rst_rows", rows, 0);
        chk("rst_cols", cols, 0);
        chk("rst_rolls", roll_count, 0);
        chk("rst_grid", (grid != '0), 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        str2q("@@.\n.@@\n@.@\n", f);   send_frame(f);
        str2q("@.\n.@", f);            send_frame(f);
        str2q("@@@\n@@\n", f);         send_frame(f);
        str2q("@x.\n", f);             send_frame(f);
        str2q("\n", f);                send_frame(f);
        str2q("@.\r\n.@\r\n\n\n", f);  send_frame(f);
        str2q("@@\n@@\r", f);          send_frame(f);
        f = {};
        repeat (WIDTH + 1) f.push_back(AT);
        f.push_back(NL);
        send_frame(f);
        gen(WIDTH, DEPTH, 9, f);       send_frame(f);
        gen(WIDTH, DEPTH + 1, 9, f);   send_frame(f);
        gen(WIDTH, 3, 1, f);           send_frame(f);

        for (int i = 0; i < 30; i++) begin
            gen($urandom_range(1, WIDTH), $urandom_range(1, DEPTH),
                $urandom_range(0, 9), f);
            send_frame(f);
        end

        drain();
        str2q("@@\n@", f);
        foreach (f[i]) send_byte(f[i], 1'b0);
        in_valid = 1'b1;
        in_data  = AT;
        rst_n    = 1'b0;
        #1;
        chk("midrst_valid", grid_valid, 0);
        chk("midrst_rows", rows, 0);
        chk("midrst_cols", cols, 0);
        chk("midrst_rolls", roll_count, 0);
        chk("midrst_grid", (grid != '0), 0);
        chk("midrst_err", grid_err, 0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        str2q(".@.\n@@@\n", f);        send_frame(f);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
